preemph_fir: RTL

PREEMPH_FIR -- requirements
Module: preemph_fir

---
 rtl/preemph_pkg.sv | 40 ++++
 rtl/preemph_coef_bank.sv | 36 +++
 rtl/preemph_fir.sv | 82 ++++++++
 3 files changed

// File: rtl/preemph_pkg.sv
// Shared helpers for the pre-emphasis FIR: accumulator sizing, signed
// saturation and the reset-time identity coefficient set.
package preemph_pkg;

  localparam int MAX_TAPS = 8;

  // Identity filter: c[0]=1, every other tap 0.
  localparam int IDENT_COEF [MAX_TAPS] = '{1, 0, 0, 0, 0, 0, 0, 0};

  typedef struct packed {
    logic               clipped;
    logic signed [63:0] val;
  } sat_res_t;

  function automatic int acc_w(input int data_w, input int coef_w, input int ntaps);
    return data_w + coef_w + $clog2(ntaps);
  endfunction

  // Clamp v into the signed range of an out_w-bit word; val stays 64-bit wide
  // so callers truncate to their own output width.
  function automatic sat_res_t sat_signed(input logic signed [63:0] v,
                                          input int unsigned out_w);
    sat_res_t           r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    r.clipped = 1'b1;
    if (v > hi) begin
      r.val = hi;
    end else if (v < lo) begin
      r.val = lo;
    end else begin
      r.val     = v;
      r.clipped = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/preemph_coef_bank.sv
// Double-buffered coefficient storage: writes land in a shadow bank, and a
// commit copies the whole shadow bank into the active bank on one edge.
module preemph_coef_bank
  import preemph_pkg::*;
#(
  parameter int COEF_W = 3,
  parameter int NTAPS  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     coef_wr,
  input  logic [$clog2(NTAPS)-1:0] coef_idx,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     coef_commit,
  output logic signed [COEF_W-1:0] coef [NTAPS]
);

  logic signed [COEF_W-1:0] shadow [NTAPS];

  // Commit reads shadow before this edge's write lands, so a simultaneous
  // write/commit copies the old value and keeps the new one in shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NTAPS; k++) begin
        shadow[k] <= COEF_W'(IDENT_COEF[k]);
        coef[k]   <= COEF_W'(IDENT_COEF[k]);
      end
    end else begin
      for (int unsigned k = 0; k < NTAPS; k++) begin
        if (coef_commit) coef[k] <= shadow[k];
        if (coef_wr && (32'(coef_idx) == k)) shadow[k] <= coef_data;
      end
    end
  end

endmodule

// File: rtl/preemph_fir.sv
// Direct-form pre-emphasis FIR with shadowed coefficients, full-precision
// accumulation, post-shift saturation and a single-cycle registered output.
module preemph_fir
  import preemph_pkg::*;
#(
  parameter int DATA_W = 13,
  parameter int COEF_W = 3,
  parameter int NTAPS  = 3,
  parameter int OUT_W  = 13,
  parameter int SHIFT  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     clr_hist,
  input  logic                     bypass,
  input  logic                     coef_wr,
  input  logic [$clog2(NTAPS)-1:0] coef_idx,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     coef_commit,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     sat_flag
);

  localparam int ACC_W = acc_w(DATA_W, COEF_W, NTAPS);

  logic signed [COEF_W-1:0] coef [NTAPS];
  logic signed [DATA_W-1:0] hist [NTAPS-1];
  logic signed [DATA_W-1:0] xk;
  logic signed [ACC_W-1:0]  acc;
  logic signed [63:0]       pre;
  sat_res_t                 sr;

  preemph_coef_bank #(
    .COEF_W(COEF_W),
    .NTAPS (NTAPS)
  ) u_bank (
    .clk        (clk),
    .rst        (rst),
    .coef_wr    (coef_wr),
    .coef_idx   (coef_idx),
    .coef_data  (coef_data),
    .coef_commit(coef_commit),
    .coef       (coef)
  );

  // A clear arriving with a sample makes this output see an all-zero history.
  always_comb begin
    xk  = '0;
    acc = ACC_W'(coef[0]) * ACC_W'(in_data);
    for (int unsigned k = 1; k < NTAPS; k++) begin
      xk  = clr_hist ? '0 : hist[k-1];
      acc = acc + ACC_W'(coef[k]) * ACC_W'(xk);
    end
    pre = bypass ? 64'(in_data) : 64'(acc >>> SHIFT);
    sr  = sat_signed(pre, OUT_W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
      for (int unsigned k = 0; k < NTAPS - 1; k++) hist[k] <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= OUT_W'(sr.val);
        sat_flag <= sr.clipped;
      end
      if (in_valid)      hist[0] <= in_data;
      else if (clr_hist) hist[0] <= '0;
      for (int unsigned k = 1; k < NTAPS - 1; k++) begin
        if (in_valid)      hist[k] <= clr_hist ? '0 : hist[k-1];
        else if (clr_hist) hist[k] <= '0;
      end
    end
  end

endmodule
